// File: rtl/dmem_responder.sv
// Responder end of the core data-memory interface: one outstanding load/store,
// programmable wait before the access, registered response held until accepted.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        hold_write;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0] widx;
  logic        err_mis, err_rng, err, access, accept;

  assign widx    = hold_addr[31:2];
  assign err_mis = hold_addr[1:0] != 2'b00;
  // Full-width compare so out-of-range indices never alias into the array
  assign err_rng = widx >= 30'(DEPTH_WORDS);
  assign err     = err_mis | err_rng;
  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign access  = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_write <= req_write;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            cnt        <= 4'(LATENCY);
            state      <= WAIT;
            req_ready  <= 1'b0;
          end else begin
            // req_ready is registered so it stays low for the whole reset window
            req_ready  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (!hold_write && !err) ? mem[widx[AW-1:0]] : 32'h0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array is not reset; an async reset pulls state out of WAIT so no write fires
  always_ff @(posedge clk) begin
    if (access && hold_write && !err)
      mem[widx[AW-1:0]] <= hold_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, corner sequences, and random traffic
// against a word-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic        req_valid[3], req_write[3], resp_ready[3];
  logic        req_ready[3], resp_valid[3], resp_err[3];
  logic [31:0] req_addr[3], req_wdata[3], resp_rdata[3];
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] model [64];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    int          stall;
  } vec_t;
  vec_t vt[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Reference: word array with alignment and range rules
  task automatic ref_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
    er = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    rd = (er || w) ? 32'h0 : model[a[7:2]];
    if (!er && w) model[a[7:2]] = d;
  endtask

  // Present a request and return just after the accepting edge
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rr, output int acc_cyc, output logic ok);
    int n;
    ok = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
    resp_ready[k] = rr;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: req_ready stuck low", k);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    ok = 1'b1;
    // Scramble inputs after the accept to show they are ignored
    req_valid[k] = 1'b0; req_write[k] = 1'($urandom);
    req_addr[k] = $urandom; req_wdata[k] = $urandom;
    chk1("req_ready_low_wait", req_ready[k], 1'b0);
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int stall, output logic [31:0] rd, output logic er,
                     output int lat, output int acc_cyc);
    logic ok;
    int n;
    rd = '0; er = 1'b0; lat = -1;
    issue(k, w, a, d, stall == 0, acc_cyc, ok);
    if (!ok) return;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (resp_valid[k]) break;
    end
    if (!resp_valid[k]) begin
      checks++; errors++;
      $display("FAIL resp_timeout dut%0d: resp_valid never rose", k);
      return;
    end
    lat = n;
    rd = resp_rdata[k];
    er = resp_err[k];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk1("stall_valid", resp_valid[k], 1'b1);
      chk("stall_rdata", resp_rdata[k], rd);
      chk1("stall_err", resp_err[k], er);
      chk1("stall_req_ready", req_ready[k], 1'b0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk1("post_hs_valid", resp_valid[k], 1'b0);
    chk("post_hs_rdata", resp_rdata[k], 32'h0);
    chk1("post_hs_err", resp_err[k], 1'b0);
    chk1("post_hs_req_ready", req_ready[k], 1'b1);
    resp_ready[k] = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd, a, d;
    logic er, eer, ok, w;
    int lat, acc, prev_acc, sel;

    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; resp_ready[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;
    end
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0, 0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 0};
    vt[2]  = '{1'b1, 32'h0000_0004, 32'h12345678, 32'h0,        1'b0, 0};
    vt[3]  = '{1'b0, 32'h0000_0004, 32'h0,        32'h12345678, 1'b0, 6};
    vt[4]  = '{1'b0, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 0};
    vt[5]  = '{1'b1, 32'h0000_0100, 32'hCAFEF00D, 32'h0,        1'b1, 0};
    vt[6]  = '{1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 0};
    vt[7]  = '{1'b1, 32'h0000_00FC, 32'h0000_0001, 32'h0,       1'b0, 1};
    vt[8]  = '{1'b0, 32'h0000_00FC, 32'h0,        32'h0000_0001, 1'b0, 0};
    vt[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b1, 2};
    vt[10] = '{1'b1, 32'h0000_0003, 32'h7777_7777, 32'h0,       1'b1, 0};
    vt[11] = '{1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req_ready", req_ready[0], 1'b0);
    chk1("rst_resp_valid", resp_valid[0], 1'b0);
    chk1("rst_resp_err", resp_err[0], 1'b0);
    chk("rst_resp_rdata", resp_rdata[0], 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk1("ready_after_release", req_ready[0], 1'b1);

    // Known array contents for the reference model
    for (int i = 0; i < 64; i++) begin
      txn(0, 1'b1, 32'(i) * 4, 32'h0, 0, rd, er, lat, acc);
      model[i] = 32'h0;
    end

    prev_acc = 0;
    for (int i = 0; i < 12; i++) begin
      txn(0, vt[i].w, vt[i].a, vt[i].d, vt[i].stall, rd, er, lat, acc);
      ref_acc(vt[i].w, vt[i].a, vt[i].d, erd, eer);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      chk1($sformatf("vec%0d_err", i), er, vt[i].er);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      if (i == 1) chk("vec1_gap", 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
    end

    // Latency extremes
    txn(1, 1'b1, 32'h8, 32'h0000_0055, 0, rd, er, lat, acc);
    chk("lat0_store_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h8, 32'h0, 0, rd, er, lat, acc);
    chk("lat0_load_lat", 32'(lat), 32'd1);
    chk("lat0_load_rdata", rd, 32'h0000_0055);
    txn(2, 1'b1, 32'hC, 32'h0000_00AA, 0, rd, er, lat, acc);
    chk("lat15_store_lat", 32'(lat), 32'd16);
    txn(2, 1'b0, 32'hC, 32'h0, 1, rd, er, lat, acc);
    chk("lat15_load_lat", 32'(lat), 32'd16);
    chk("lat15_load_rdata", rd, 32'h0000_00AA);

    // Reset in the first WAIT cycle drops the store
    issue(0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, acc, ok);
    reset = 1'b0;
    #1;
    chk1("midrst_resp_valid", resp_valid[0], 1'b0);
    chk1("midrst_req_ready", req_ready[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk1("midrst_resp_valid_hold", resp_valid[0], 1'b0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk1("midrst_ready_after_release", req_ready[0], 1'b1);
    txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, acc);
    chk("midrst_load_rdata", rd, model[8]);
    chk1("midrst_load_err", er, 1'b0);

    // Reset in RESP keeps a committed store
    issue(0, 1'b1, 32'h24, 32'h0000_0777, 1'b0, acc, ok);
    ref_acc(1'b1, 32'h24, 32'h0000_0777, erd, eer);
    repeat (3) @(posedge clk);
    #1;
    chk1("resprst_valid_before", resp_valid[0], 1'b1);
    reset = 1'b0;
    #1;
    chk1("resprst_valid_drop", resp_valid[0], 1'b0);
    @(negedge clk) reset = 1'b1;
    txn(0, 1'b0, 32'h24, 32'h0, 0, rd, er, lat, acc);
    chk("resprst_load_rdata", rd, 32'h0000_0777);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      w = 1'($urandom);
      d = $urandom;
      a = 32'($urandom_range(0, 63)) * 4;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = ($urandom | 32'h100) & ~32'h3;
      txn(0, w, a, d, $urandom_range(0, 3), rd, er, lat, acc);
      ref_acc(w, a, d, erd, eer);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk1($sformatf("rnd%0d_err", i), er, eer);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory interface: accepts one load/store request at a time from a multi-cycle core, waits a programmable number of cycles, then returns read data or write acknowledge.
- Owns a word-addressed SRAM array.
- Sits between the core datapath's alu_out/dmem_write_data outputs and the dmem_read_data input. Used as the memory model for the multi-cycle and pipelined core bring-up.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array; power of two, ≥4.
- LATENCY, 2, wait cycles inserted before the access (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access.

Behaviour:

Reset:
- reset low forces, asynchronously: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- Array contents are not reset.
- req_ready rises in the first cycle after reset is released.

States and transitions:
- IDLE:
  - req_ready=1, resp_valid=0.
  - Accept on a rising edge with req_valid&&req_ready.
  - At accept: capture req_write, req_addr, req_wdata into holding registers; load counter=LATENCY; go to WAIT.
  - Core inputs are ignored after the accepting edge.
- WAIT:
  - req_ready=0.
  - Each edge with counter≠0: decrement.
  - Edge with counter==0: perform the access from the held registers, register the response, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until the handshake.
  - Edge with resp_valid&&resp_ready: go to IDLE; resp_valid, resp_rdata and resp_err clear to 0.
  - resp_ready while not in RESP is ignored.

Latency:
- resp_valid first high after the (LATENCY+1)th edge following the accepting edge.
- Minimum request-to-request spacing is LATENCY+3 cycles with resp_ready tied high.
- No request is accepted while a response is pending: one outstanding transaction.

Addressing and error checks:
- word index = held_addr[31:2].
- err_misaligned = held_addr[1:0]≠0.
- err_range = word index ≥ DEPTH_WORDS (full 30-bit compare; no aliasing or wrap).
- Either check → resp_err=1, no array write, resp_rdata=0.

Access:
- Load, no error: resp_rdata = mem[index], resp_err=0.
- Store, no error: mem[index] = held wdata, committed on the access edge; resp_rdata=0, resp_err=0.
- Store then load to the same address returns the new data.

Reset during a transaction:
- Reset asserted in WAIT before the access edge: the pending store is dropped and the array is unchanged.
- Reset asserted in RESP: resp_valid drops immediately; a store already committed remains in the array.

Other rules:
- req_valid high during reset or WAIT/RESP has no effect; the core must hold it until req_ready.
- req_ready is a registered-state decode only, with no combinational path from req_valid.

Test Plan:
- LATENCY=2, resp_ready=1: store 0xDEADBEEF @0x10, then load @0x10 → resp_valid 3 edges after each accept; load resp_rdata=0xDEADBEEF, resp_err=0; second accept occurs 5 cycles after the first.
- Backpressure: load @0x04 (mem=0x12345678), hold resp_ready=0 for 6 cycles → resp_valid and resp_rdata=0x12345678 stable all 6 cycles, req_ready=0 throughout; IDLE one edge after resp_ready=1.
- Errors: load @0x0000_0102 → resp_err=1, rdata=0. Store @0x100 (index 64, DEPTH 64) → resp_err=1, and a reread of @0x000 is unchanged (no aliasing).
- LATENCY=0: load accepted at edge E0 → resp_valid after E1. LATENCY=15 → resp_valid after E16.
- Reset mid-operation: store 0xA5A5A5A5 @0x20 (prior 0x0), assert reset in the first WAIT cycle → resp_valid never rises; after release, load @0x20 returns 0x0 and req_ready is 1 the first cycle after release.
- Random mix of 500 loads and stores at valid and invalid addresses with random resp_ready stalls, checked against a scoreboard → all data, err flags and latencies match.
